// File: rtl/key_event_ctrl.sv
// Classifies debounced key presses as SHORT or LONG and serialises the
// resulting events from all keys onto one valid/ready port (round-robin).
module key_event_ctrl #(
    parameter int unsigned NUM_KEYS  = 4,
    parameter int unsigned KEY_IDX_W = 2,
    parameter int unsigned LONG_CNT  = 25_000_000,
    parameter int unsigned CNT_W     = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_KEYS-1:0]  key_flag,
    input  logic [NUM_KEYS-1:0]  key_state,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [KEY_IDX_W-1:0] evt_key,
    output logic [1:0]           evt_type,
    output logic                 ovr
);

    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(LONG_CNT - 1);
    localparam logic [1:0]       TYPE_SHORT = 2'b01;
    localparam logic [1:0]       TYPE_LONG  = 2'b10;
    localparam int               NK         = int'(NUM_KEYS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HELD    = 2'd1,
        S_LATCHED = 2'd2
    } key_st_t;

    key_st_t              r_state     [NUM_KEYS];
    key_st_t              w_state_nxt [NUM_KEYS];
    logic [CNT_W-1:0]     r_cnt       [NUM_KEYS];
    logic [CNT_W-1:0]     w_cnt_nxt   [NUM_KEYS];
    logic [1:0]           w_post_type [NUM_KEYS];
    logic [1:0]           r_pend_type [NUM_KEYS];
    logic [NUM_KEYS-1:0]  w_press;
    logic [NUM_KEYS-1:0]  w_rel;
    logic [NUM_KEYS-1:0]  w_post;
    logic [NUM_KEYS-1:0]  w_take;
    logic [NUM_KEYS-1:0]  r_pend;

    logic                 r_evt_valid;
    logic [KEY_IDX_W-1:0] r_evt_key;
    logic [1:0]           r_evt_type;
    logic                 r_ovr;
    logic [KEY_IDX_W-1:0] r_ptr;
    logic                 r_first;

    logic                 w_free;
    logic                 w_gnt_vld;
    logic [KEY_IDX_W-1:0] w_gnt_idx;
    logic [1:0]           w_gnt_type;
    int                   w_start;
    int                   w_best;
    int                   w_dist;

    assign w_press = key_flag & ~key_state;
    assign w_rel   = key_flag & key_state;
    assign w_free  = ~r_evt_valid | evt_ready;

    // Per-key state register and hold counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NK; k++) begin
                r_state[k] <= S_IDLE;
                r_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_cnt[k]   <= w_cnt_nxt[k];
            end
        end
    end

    // Per-key next state; the counter saturates at CNT_MAX so it never wraps
    always_comb begin
        for (int k = 0; k < NK; k++) begin
            w_state_nxt[k] = r_state[k];
            w_cnt_nxt[k]   = r_cnt[k];
            case (r_state[k])
                S_IDLE: begin
                    w_cnt_nxt[k] = '0;
                    if (w_press[k]) w_state_nxt[k] = S_HELD;
                end
                S_HELD: begin
                    if (w_rel[k]) begin
                        w_state_nxt[k] = S_IDLE;
                        w_cnt_nxt[k]   = '0;
                    end else if (r_cnt[k] == CNT_MAX) begin
                        w_state_nxt[k] = S_LATCHED;
                    end else begin
                        w_cnt_nxt[k] = r_cnt[k] + CNT_W'(1);
                    end
                end
                S_LATCHED: begin
                    if (w_rel[k]) begin
                        w_state_nxt[k] = S_IDLE;
                        w_cnt_nxt[k]   = '0;
                    end
                end
                default: begin
                    w_state_nxt[k] = S_IDLE;
                    w_cnt_nxt[k]   = '0;
                end
            endcase
        end
    end

    // Event posting; a release on the final count cycle still reads as SHORT
    always_comb begin
        w_post = '0;
        for (int k = 0; k < NK; k++) begin
            w_post_type[k] = TYPE_SHORT;
            if (r_state[k] == S_HELD) begin
                if (w_rel[k]) begin
                    w_post[k] = 1'b1;
                end else if (r_cnt[k] == CNT_MAX) begin
                    w_post[k]      = 1'b1;
                    w_post_type[k] = TYPE_LONG;
                end
            end
        end
    end

    // Round-robin pick: smallest rotational distance from the search start
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_type = 2'b00;
        w_best     = NK;
        w_dist     = 0;
        w_start    = r_first ? 0 : int'(r_ptr) + 1;
        for (int k = 0; k < NK; k++) begin
            w_dist = (k + NK - w_start) % NK;
            if (r_pend[k] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_gnt_vld  = 1'b1;
                w_gnt_idx  = KEY_IDX_W'(k);
                w_gnt_type = r_pend_type[k];
            end
        end
        w_take = '0;
        for (int k = 0; k < NK; k++) begin
            w_take[k] = w_free && w_gnt_vld && (w_gnt_idx == KEY_IDX_W'(k));
        end
    end

    // Output register, pending slots and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_evt_valid <= 1'b0;
            r_evt_key   <= '0;
            r_evt_type  <= 2'b00;
            r_ovr       <= 1'b0;
            r_ptr       <= '0;
            r_first     <= 1'b1;
            r_pend      <= '0;
            for (int k = 0; k < NK; k++) r_pend_type[k] <= 2'b00;
        end else begin
            if (w_free) begin
                if (w_gnt_vld) begin
                    r_evt_valid <= 1'b1;
                    r_evt_key   <= w_gnt_idx;
                    r_evt_type  <= w_gnt_type;
                    r_ptr       <= w_gnt_idx;
                    r_first     <= 1'b0;
                end else begin
                    r_evt_valid <= 1'b0;
                end
            end
            for (int k = 0; k < NK; k++) begin
                if (w_post[k]) begin
                    r_pend[k]      <= 1'b1;
                    r_pend_type[k] <= w_post_type[k];
                    if (r_pend[k] && !w_take[k]) r_ovr <= 1'b1;
                end else if (w_take[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_key   = r_evt_key;
    assign evt_type  = r_evt_type;
    assign ovr       = r_ovr;

endmodule
